// File: rtl/ttio_tq.sv
// ttio_tq -- time-triggered output queue.
//
// ICB slave that accepts timestamped output words, holds them in a small FIFO
// and presents each word on a parallel port once mtime reaches its timestamp.
//
// Register map (word offset addr[3:2]):
//   0 TS     : write stages a 32-bit timestamp (reads as 0)
//   1 DATA   : write pushes {ts_stage, wdata[OUT_W-1:0]} (reads as 0)
//   2 STATUS : read-only, [4:0] count, [8] empty, [9] full, [10] late_sticky
//   3 CTRL   : [0] en, [3] irq_en (r/w); [1] flush, [2] late_clr (write-1 pulses)
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   icb_cmd_*           ICB command channel (single outstanding transaction)
//   icb_rsp_*           ICB response channel
//   mtime               free-running time base, low 32 bits
//   tq_o_dat            last fired word, held until the next fire
//   tq_o_strobe         one-cycle pulse per fire
//   tq_o_irq            level interrupt: late_sticky & irq_en
module ttio_tq #(
  parameter int DEPTH  = 4,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icb_cmd_valid,
  output logic                icb_cmd_ready,
  input  logic [ADDR_W-1:0]   icb_cmd_addr,
  input  logic                icb_cmd_read,
  input  logic [XLEN-1:0]     icb_cmd_wdata,
  input  logic [XLEN/8-1:0]   icb_cmd_wmask,
  output logic                icb_rsp_valid,
  input  logic                icb_rsp_ready,
  output logic                icb_rsp_err,
  output logic [XLEN-1:0]     icb_rsp_rdata,
  input  logic [31:0]         mtime,
  output logic [OUT_W-1:0]    tq_o_dat,
  output logic                tq_o_strobe,
  output logic                tq_o_irq
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] REG_TS     = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // Register word packing.
  function automatic logic [31:0] pack_status(input logic [4:0] c, input logic e,
                                              input logic f, input logic l);
    return {21'd0, l, f, e, 3'd0, c};
  endfunction

  function automatic logic [31:0] pack_ctrl(input logic en_b, input logic irq_en_b);
    return {28'd0, irq_en_b, 2'b00, en_b};
  endfunction

  // Control state
  logic                 en;
  logic                 irq_en;
  logic                 late_sticky;
  logic [31:0]          ts_stage;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [4:0]           cnt;

  // FIFO storage (data only, never reset)
  logic [31:0]          ts_mem  [DEPTH];
  logic [OUT_W-1:0]     dat_mem [DEPTH];

  // Response and output stage registers
  logic                 rsp_vld_p1;
  logic                 rsp_err_p1;
  logic [XLEN-1:0]      rsp_rdata_p1;
  logic                 out_vld_p1;
  logic [OUT_W-1:0]     out_dat_p1;

  // Command decode
  logic                 accept_p0;
  logic [1:0]           reg_idx_p0;
  logic                 mask_ok_p0;
  logic                 wr_ok_p0;
  logic                 push_p0;
  logic                 ts_wr_p0;
  logic                 ctrl_wr_p0;
  logic                 flush_p0;
  logic                 late_clr_p0;
  logic                 cmd_err_p0;
  logic [XLEN-1:0]      rd_word_p0;

  // Fire evaluation
  logic                 empty;
  logic                 full;
  logic [31:0]          head_ts_p0;
  logic signed [31:0]   time_diff_p0;
  logic                 fire_p0;
  logic                 late_hit_p0;

  logic                 unused_addr;
  assign unused_addr = ^{icb_cmd_addr[ADDR_W-1:4], icb_cmd_addr[1:0]};

  assign empty = (cnt == 5'd0);
  assign full  = (cnt == 5'(DEPTH));

  // ---- Stage p0: command decode and fire evaluation ----
  assign icb_cmd_ready = !rsp_vld_p1;
  assign accept_p0     = icb_cmd_valid & icb_cmd_ready;
  assign reg_idx_p0    = icb_cmd_addr[3:2];
  assign mask_ok_p0    = &icb_cmd_wmask;
  assign wr_ok_p0      = accept_p0 & !icb_cmd_read & mask_ok_p0;

  assign ts_wr_p0      = wr_ok_p0 & (reg_idx_p0 == REG_TS);
  assign push_p0       = wr_ok_p0 & (reg_idx_p0 == REG_DATA) & !full;
  assign ctrl_wr_p0    = wr_ok_p0 & (reg_idx_p0 == REG_CTRL);
  assign flush_p0      = ctrl_wr_p0 & icb_cmd_wdata[1];
  assign late_clr_p0   = ctrl_wr_p0 & icb_cmd_wdata[2];

  always_comb begin
    cmd_err_p0 = 1'b0;
    if (!icb_cmd_read) begin
      if (!mask_ok_p0)
        cmd_err_p0 = 1'b1;
      else if (reg_idx_p0 == REG_STATUS)
        cmd_err_p0 = 1'b1;
      else if ((reg_idx_p0 == REG_DATA) && full)
        cmd_err_p0 = 1'b1;
    end
  end

  // STATUS reflects the state registered before this accept edge.
  always_comb begin
    rd_word_p0 = '0;
    if (icb_cmd_read) begin
      case (reg_idx_p0)
        REG_STATUS: rd_word_p0 = XLEN'(pack_status(cnt, empty, full, late_sticky));
        REG_CTRL:   rd_word_p0 = XLEN'(pack_ctrl(en, irq_en));
        default:    rd_word_p0 = '0;
      endcase
    end
  end

  // Wrap-safe comparison: the head is due when mtime - head_ts is
  // non-negative as a signed 32-bit value, so anything up to 2^31-1 ticks
  // ahead counts as future even across the mtime wrap. A flush in the same
  // cycle suppresses the fire.
  assign head_ts_p0   = ts_mem[rd_ptr];
  assign time_diff_p0 = signed'(mtime - head_ts_p0);
  assign fire_p0      = en & !empty & (time_diff_p0 >= 32'sd0) & !flush_p0;
  assign late_hit_p0  = fire_p0 & (mtime != head_ts_p0);

  // ---- Stage p1: registered control, FIFO pointers, response and output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      en           <= 1'b0;
      irq_en       <= 1'b0;
      late_sticky  <= 1'b0;
      ts_stage     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      rsp_vld_p1   <= 1'b0;
      rsp_err_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
      out_vld_p1   <= 1'b0;
      out_dat_p1   <= '0;
    end else begin
      if (ts_wr_p0)
        ts_stage <= icb_cmd_wdata[31:0];

      if (ctrl_wr_p0) begin
        en     <= icb_cmd_wdata[0];
        irq_en <= icb_cmd_wdata[3];
      end

      // A late fire in the same cycle as late_clr keeps the flag set.
      if (late_hit_p0)
        late_sticky <= 1'b1;
      else if (late_clr_p0)
        late_sticky <= 1'b0;

      if (flush_p0) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push_p0)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (fire_p0)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push_p0, fire_p0})
          2'b10:   cnt <= cnt + 5'd1;
          2'b01:   cnt <= cnt - 5'd1;
          default: cnt <= cnt;
        endcase
      end

      // Response is held stable until the requester takes it.
      if (accept_p0) begin
        rsp_vld_p1   <= 1'b1;
        rsp_err_p1   <= cmd_err_p0;
        rsp_rdata_p1 <= rd_word_p0;
      end else if (icb_rsp_ready) begin
        rsp_vld_p1   <= 1'b0;
      end

      out_vld_p1 <= fire_p0;
      if (fire_p0)
        out_dat_p1 <= dat_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      ts_mem[wr_ptr]  <= ts_stage;
      dat_mem[wr_ptr] <= icb_cmd_wdata[OUT_W-1:0];
    end
  end

  assign icb_rsp_valid = rsp_vld_p1;
  assign icb_rsp_err   = rsp_err_p1;
  assign icb_rsp_rdata = rsp_rdata_p1;
  assign tq_o_dat      = out_dat_p1;
  assign tq_o_strobe   = out_vld_p1;
  assign tq_o_irq      = late_sticky & irq_en;

endmodule

// File: tb/tb_ttio_tq.sv
// Directed testbench for ttio_tq.
module tb_ttio_tq;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic [31:0] mtime;
  logic [7:0]  tq_o_dat;
  logic        tq_o_strobe;
  logic        tq_o_irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_TS     = 32'h0;
  localparam logic [31:0] A_DATA   = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_CTRL   = 32'hC;

  ttio_tq #(.DEPTH(4), .OUT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata),
    .mtime         (mtime),
    .tq_o_dat      (tq_o_dat),
    .tq_o_strobe   (tq_o_strobe),
    .tq_o_irq      (tq_o_irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic icb_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic err);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wmask = m;
    cyc();
    icb_cmd_valid = 1'b0;
    err = icb_rsp_err;
    cyc();
  endtask

  task automatic icb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = a;
    icb_cmd_wdata = 32'h0;
    icb_cmd_wmask = 4'hF;
    cyc();
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    d   = icb_rsp_rdata;
    err = icb_rsp_err;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    rst = 1'b1;
    icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = 4'hF; icb_rsp_ready = 1'b1; mtime = '0;
    cyc(); cyc(); cyc();
    checks++;
    if ({icb_cmd_ready, icb_rsp_valid, icb_rsp_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_icb: got ready/valid/err=%b required 100",
               {icb_cmd_ready, icb_rsp_valid, icb_rsp_err});
    end
    checks++;
    if ({icb_rsp_rdata, tq_o_dat, tq_o_strobe, tq_o_irq} !== 42'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h dat=%h strobe=%b irq=%b required all 0",
               icb_rsp_rdata, tq_o_dat, tq_o_strobe, tq_o_irq);
    end
    rst = 1'b0;
    cyc();
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100 || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %h err=%b required 00000100 err=0", d, e);
    end
    icb_rd(A_CTRL, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required 00000000", d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic e;
    icb_wr(A_TS, 32'h1234, 4'h7, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_partial_mask: got err=%b required 1", e); end
    icb_wr(A_STATUS, 32'h0, 4'hF, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_status_write: got err=%b required 1", e); end
    icb_wr(A_DATA, 32'h99, 4'hE, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_data_mask: got err=%b required 1", e); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL err_no_side_effect: got status %h required 00000100", d); end
    icb_rd(A_TS, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL ts_read_zero: got %h err=%b required 0 err=0", d, e);
    end
  endtask

  task automatic test_basic_fire();
    logic [31:0] d;
    logic e;
    int n_fire = 0;
    logic [31:0] fire_m = '0;
    icb_wr(A_CTRL, 32'h1, 4'hF, e);
    mtime = 32'd90;
    icb_wr(A_TS, 32'd100, 4'hF, e);
    icb_wr(A_DATA, 32'hA5, 4'hF, e);
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h001) begin errors++; $display("FAIL basic_count1: got %h required 00000001", d); end
    for (int m = 91; m <= 105; m++) begin
      mtime = 32'(m);
      cyc();
      if (tq_o_strobe === 1'b1) begin n_fire++; fire_m = 32'(m); end
    end
    checks++;
    if (n_fire != 1 || fire_m !== 32'd100) begin
      errors++; $display("FAIL basic_strobe: got %0d strobes, at mtime %0d required 1 at 100", n_fire, fire_m);
    end
    checks++;
    if (tq_o_dat !== 8'hA5) begin errors++; $display("FAIL basic_dat: got %h required a5", tq_o_dat); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL basic_status_after: got %h required 00000100", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic e;
    logic [7:0] exp_dat [4];
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h33; exp_dat[3] = 8'h44;
    icb_wr(A_CTRL, 32'h0, 4'hF, e);
    mtime = 32'd1000;
    for (int i = 0; i < 4; i++) begin
      icb_wr(A_TS, 32'(10 * (i + 1)), 4'hF, e);
      icb_wr(A_DATA, {24'h0, exp_dat[i]}, 4'hF, e);
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL ovf_push%0d_err: got %b required 0", i, e); end
    end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h204) begin errors++; $display("FAIL ovf_full_status: got %h required 00000204", d); end
    icb_wr(A_TS, 32'd50, 4'hF, e);
    icb_wr(A_DATA, 32'h55, 4'hF, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL ovf_fifth_err: got %b required 1", e); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h204) begin errors++; $display("FAIL ovf_count_kept: got %h required 00000204", d); end
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = A_CTRL;
    icb_cmd_wdata = 32'h1; icb_cmd_wmask = 4'hF;
    cyc();
    icb_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (tq_o_strobe !== 1'b1 || tq_o_dat !== exp_dat[i]) begin
        errors++;
        $display("FAIL ovf_drain%0d: got strobe=%b dat=%h required 1 %h", i, tq_o_strobe, tq_o_dat, exp_dat[i]);
      end
    end
    cyc();
    checks++;
    if (tq_o_strobe !== 1'b0) begin errors++; $display("FAIL ovf_drain_end: got strobe=%b required 0", tq_o_strobe); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h500) begin errors++; $display("FAIL ovf_late_status: got %h required 00000500", d); end
    icb_wr(A_CTRL, 32'h4, 4'hF, e);
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL ovf_late_clr: got %h required 00000100", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic e;
    int n_fire = 0;
    logic [31:0] fire_m = '0;
    logic [31:0] m;
    icb_wr(A_CTRL, 32'h1, 4'hF, e);
    mtime = 32'hFFFF_FFF0;
    icb_wr(A_TS, 32'h5, 4'hF, e);
    icb_wr(A_DATA, 32'h5A, 4'hF, e);
    for (int i = 0; i < 24; i++) begin
      m = 32'hFFFF_FFF1 + 32'(i);
      mtime = m;
      cyc();
      if (tq_o_strobe === 1'b1) begin n_fire++; fire_m = m; end
    end
    checks++;
    if (n_fire != 1 || fire_m !== 32'h5) begin
      errors++; $display("FAIL wrap_fire: got %0d strobes at mtime %h required 1 at 00000005", n_fire, fire_m);
    end
    checks++;
    if (tq_o_dat !== 8'h5A) begin errors++; $display("FAIL wrap_dat: got %h required 5a", tq_o_dat); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL wrap_not_late: got %h required 00000100", d); end
  endtask

  task automatic test_late_irq();
    logic [31:0] d;
    logic e;
    logic seen;
    icb_wr(A_CTRL, 32'h9, 4'hF, e);
    mtime = 32'd50;
    icb_wr(A_TS, 32'd10, 4'hF, e);
    icb_wr(A_DATA, 32'h77, 4'hF, e);
    seen = tq_o_strobe;
    for (int i = 0; i < 2; i++) begin
      if (!seen) begin cyc(); seen = tq_o_strobe; end
    end
    checks++;
    if (seen !== 1'b1 || tq_o_dat !== 8'h77) begin
      errors++; $display("FAIL late_fire: got seen=%b dat=%h required 1 77", seen, tq_o_dat);
    end
    checks++;
    if (tq_o_irq !== 1'b1) begin errors++; $display("FAIL late_irq_set: got %b required 1", tq_o_irq); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h500) begin errors++; $display("FAIL late_status: got %h required 00000500", d); end
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = A_CTRL;
    icb_cmd_wdata = 32'hD; icb_cmd_wmask = 4'hF;
    cyc();
    icb_cmd_valid = 1'b0;
    checks++;
    if (tq_o_irq !== 1'b0) begin errors++; $display("FAIL late_irq_clr: got %b required 0", tq_o_irq); end
    cyc();
    icb_rd(A_CTRL, d, e);
    checks++;
    if (d !== 32'h9) begin errors++; $display("FAIL ctrl_readback: got %h required 00000009", d); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic e;
    mtime = 32'd200;
    icb_wr(A_TS, 32'd300, 4'hF, e);
    icb_wr(A_DATA, 32'h01, 4'hF, e);
    icb_wr(A_DATA, 32'h02, 4'hF, e);
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h002) begin errors++; $display("FAIL sim_count2: got %h required 00000002", d); end
    // Push lands in the same cycle the head becomes due.
    mtime = 32'd300;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = A_DATA;
    icb_cmd_wdata = 32'h03; icb_cmd_wmask = 4'hF;
    cyc();
    mtime = 32'd200;
    icb_cmd_valid = 1'b0;
    checks++;
    if (tq_o_strobe !== 1'b1 || tq_o_dat !== 8'h01 || icb_rsp_err !== 1'b0) begin
      errors++; $display("FAIL sim_push_pop: got strobe=%b dat=%h err=%b required 1 01 0",
                         tq_o_strobe, tq_o_dat, icb_rsp_err);
    end
    cyc();
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h002) begin errors++; $display("FAIL sim_count_kept: got %h required 00000002", d); end
    // Flush in the same cycle as a due head.
    mtime = 32'd300;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = A_CTRL;
    icb_cmd_wdata = 32'h3; icb_cmd_wmask = 4'hF;
    cyc();
    icb_cmd_valid = 1'b0;
    checks++;
    if (tq_o_strobe !== 1'b0) begin errors++; $display("FAIL sim_flush_nofire: got strobe=%b required 0", tq_o_strobe); end
    cyc();
    checks++;
    if (tq_o_strobe !== 1'b0) begin errors++; $display("FAIL sim_flush_after: got strobe=%b required 0", tq_o_strobe); end
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100 || tq_o_dat !== 8'h01) begin
      errors++; $display("FAIL sim_flush_empty: got status=%h dat=%h required 00000100 01", d, tq_o_dat);
    end
  endtask

  task automatic test_handshake_reset();
    logic [31:0] d;
    logic e;
    icb_wr(A_CTRL, 32'h0, 4'hF, e);
    icb_wr(A_TS, 32'd5, 4'hF, e);
    icb_wr(A_DATA, 32'h66, 4'hF, e);
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = A_STATUS;
    cyc();
    icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h001 || icb_cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_rsp%0d: got valid=%b rdata=%h cmd_ready=%b required 1 00000001 0",
                 i, icb_rsp_valid, icb_rsp_rdata, icb_cmd_ready);
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (icb_rsp_valid !== 1'b0 || icb_cmd_ready !== 1'b1 || tq_o_dat !== 8'h00) begin
      errors++; $display("FAIL reset_mid_rsp: got valid=%b cmd_ready=%b dat=%h required 0 1 00",
                         icb_rsp_valid, icb_cmd_ready, tq_o_dat);
    end
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    icb_rd(A_STATUS, d, e);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL reset_fifo_empty: got %h required 00000100", d); end
  endtask

  initial begin
    test_reset();
    test_errors();
    test_basic_fire();
    test_overflow();
    test_wrap();
    test_late_irq();
    test_simultaneous();
    test_handshake_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
